ksa_swap_fsm: RTL
=================

# ksa_swap_fsm

Key-scheduling stage of the RC4 decryptor. It runs after the s-memory initialiser has written s[i]=i for i=0..255, and it owns the s-memory port while active. For i=0..255 it computes j = j + s[i] + key[i mod 3] (mod 256) and swaps s[i] with s[j]. The scrambled s-memory is then handed to the PRGA/decrypt stage that fills d-memory.

## Interface
- RD_WAIT, 1: extra cycles the FSM holds a read address before sampling q; must be ≥1 to cover the s-memory registered-address latency.
- clk  input  1  system clock (CLOCK_50).
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  level; the init stage's finished flag, sampled only in IDLE.
- secret_key  input  24  key; key[0]=secret_key[23:16], key[1]=[15:8], key[2]=[7:0].
- q  input  8  s-memory read data.
- address  output  8  s-memory address.
- data  output  8  s-memory write data.
- wren  output  1  s-memory write enable, one cycle per write.
- busy  output  1  high in every state except IDLE and DONE.
- done  output  1  high in DONE only.

## Operation
- Registers: i[7:0], j[7:0], si[7:0] (captured s[i]), sj[7:0] (captured s[j]); all arithmetic is 8-bit with natural wrap.
- States:
  - IDLE: address=0, wren=0. If start=1, clear i and j, then go to RD_I.
  - RD_I: address=i for 1+RD_WAIT cycles; on the last cycle capture si<=q, then go to CALC_J.
  - CALC_J: j<=j+si+key[i mod 3], then go to RD_J. The i mod 3 selector is a 2-bit counter that wraps 2→0 and advances with i; no divider.
  - RD_J: address=j for 1+RD_WAIT cycles; capture sj<=q, then go to WR_I.
  - WR_I: address=i, data=sj, wren=1, then go to WR_J.
  - WR_J: address=j, data=si, wren=1. If i==255 go to DONE; otherwise i<=i+1 and go to RD_I.
  - DONE: done=1, busy=0, wren=0. Return to IDLE only when start=0. A start held high does not retrigger.
- i==j is not special without the macro: the same value is written twice and the result is correct.
- start is ignored outside IDLE.
- Reset mid-operation: async return to IDLE with i=j=si=sj=0. The s-memory contents are then partial, and a correct result requires the init stage to rerun.
- Top-level muxes the s-memory port to this block while init is finished.

## Timing
- Reset values: address=0, data=0, wren=0, busy=0, done=0; state IDLE.
- start sampled high in IDLE → busy high the next cycle.
- Per iteration: 2*(1+RD_WAIT)+3 cycles, which is 7 at the default.
- Full run: 256*(2*RD_WAIT+5) cycles from the first RD_I cycle to the first DONE cycle, which is 1792 at the default.
- wren is never high in two non-consecutive-state cycles of the same iteration other than WR_I and WR_J.
- wren is never high in IDLE, RD_*, CALC_J or DONE.
- Outputs are registered. No combinational path exists from q to address, data or wren.

## Configuration
- KSA_SAME_INDEX_SKIP_EN defined: in CALC_J, if the new j equals i, skip RD_J/WR_I/WR_J.
  - If i==255, go to DONE; otherwise i<=i+1 and go to RD_I.
  - That iteration costs RD_WAIT+2 cycles, which is 3 at the default.
  - Final memory contents are identical to the macro-off case.
- Undefined: every iteration takes the full 2*RD_WAIT+5 cycles; total run length is key-independent.

## Test plan
- Reset: assert reset_n=0 mid-RD_J → outputs are immediately 0/IDLE. After release with start=0, busy stays 0 indefinitely.
- Key 0x000000, RD_WAIT=1, macro off:
  - iteration i=2 writes s[2]=3, s[3]=2 (j goes 0,1,3).
  - done rises exactly 1792 cycles after the first RD_I cycle.
- Key 0x000249 against a C RC4-KSA reference model → all 256 s-memory words match after done. Also check s is a permutation of 0..255.
- Macro on, key 0x000000 → iterations i=0 and i=1 each take 3 cycles with no wren pulses; final memory equals the macro-off run.
- Handshake: hold start=1 through DONE → no second run. Drop start for 1 cycle and raise it again → second run starts from i=0 with done low.
- Write monitor: over a full run, wren pulses exactly 512 times with the macro off, and never with address outside the current i/j.

Source files
------------

// File: rtl/ksa_swap_fsm_if.sv
// s-memory port and start/done handshake of the RC4 key-scheduling stage.
// master = the swap FSM, slave = top-level mux / memory side.
interface ksa_swap_fsm_if;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        busy;
    logic        done;

    modport master (
        input  start, secret_key, q,
        output address, data, wren, busy, done
    );

    modport slave (
        output start, secret_key, q,
        input  address, data, wren, busy, done
    );
endinterface

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling stage: for i=0..255, j += s[i] + key[i mod 3]; swap s[i], s[j].
// Optional build macro KSA_SAME_INDEX_SKIP_EN skips the read/swap when the new j equals i.
module ksa_swap_fsm #(
    parameter int RD_WAIT = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    ksa_swap_fsm_if.master bus
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_I   = 3'd1;
    localparam logic [2:0] S_CALC_J = 3'd2;
    localparam logic [2:0] S_RD_J   = 3'd3;
    localparam logic [2:0] S_WR_I   = 3'd4;
    localparam logic [2:0] S_WR_J   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [7:0] WAIT_LAST = 8'(RD_WAIT);
    localparam logic [7:0] I_LAST    = 8'hFF;

    logic [2:0] state_r, state_s;
    logic [7:0] i_r, i_s, j_r, j_s, si_r, si_s, sj_r, sj_s;
    logic [1:0] ksel_r, ksel_s, ksel_inc_s;
    logic [7:0] wcnt_r, wcnt_s;
    logic [7:0] address_r, address_s, data_r, data_s;
    logic       wren_r, wren_s, busy_r, done_r;
    logic [7:0] key_byte_s, j_calc_s;

    // Key byte selection (i mod 3 tracked by a wrapping 2-bit counter) and new j.
    always_comb begin
        case (ksel_r)
            2'd0:    key_byte_s = bus.secret_key[23:16];
            2'd1:    key_byte_s = bus.secret_key[15:8];
            2'd2:    key_byte_s = bus.secret_key[7:0];
            default: key_byte_s = 8'h00;
        endcase
        if (ksel_r == 2'd2) begin
            ksel_inc_s = 2'd0;
        end else begin
            ksel_inc_s = ksel_r + 2'd1;
        end
        j_calc_s = j_r + si_r + key_byte_s;
    end

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_s   = state_r;
        i_s       = i_r;
        j_s       = j_r;
        si_s      = si_r;
        sj_s      = sj_r;
        ksel_s    = ksel_r;
        wcnt_s    = wcnt_r;
        address_s = address_r;
        data_s    = data_r;
        wren_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                address_s = 8'h00;
                if (bus.start) begin
                    i_s     = 8'h00;
                    j_s     = 8'h00;
                    ksel_s  = 2'd0;
                    wcnt_s  = 8'h00;
                    state_s = S_RD_I;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_RD_I: begin
                address_s = i_r;
                if (wcnt_r == WAIT_LAST) begin
                    si_s    = bus.q;
                    wcnt_s  = 8'h00;
                    state_s = S_CALC_J;
                end else begin
                    wcnt_s  = wcnt_r + 8'd1;
                end
            end
            S_CALC_J: begin
                j_s = j_calc_s;
`ifdef KSA_SAME_INDEX_SKIP_EN
                if (j_calc_s == i_r) begin
                    if (i_r == I_LAST) begin
                        address_s = 8'h00;
                        state_s   = S_DONE;
                    end else begin
                        i_s       = i_r + 8'd1;
                        ksel_s    = ksel_inc_s;
                        address_s = i_r + 8'd1;
                        state_s   = S_RD_I;
                    end
                end else begin
                    address_s = j_calc_s;
                    state_s   = S_RD_J;
                end
`else
                address_s = j_calc_s;
                state_s   = S_RD_J;
`endif
            end
            S_RD_J: begin
                address_s = j_r;
                if (wcnt_r == WAIT_LAST) begin
                    // sj and the WR_I write data are both taken from the same q sample.
                    sj_s      = bus.q;
                    wcnt_s    = 8'h00;
                    address_s = i_r;
                    data_s    = bus.q;
                    wren_s    = 1'b1;
                    state_s   = S_WR_I;
                end else begin
                    wcnt_s    = wcnt_r + 8'd1;
                end
            end
            S_WR_I: begin
                address_s = j_r;
                data_s    = si_r;
                wren_s    = 1'b1;
                state_s   = S_WR_J;
            end
            S_WR_J: begin
                if (i_r == I_LAST) begin
                    address_s = 8'h00;
                    state_s   = S_DONE;
                end else begin
                    i_s       = i_r + 8'd1;
                    ksel_s    = ksel_inc_s;
                    address_s = i_r + 8'd1;
                    state_s   = S_RD_I;
                end
            end
            S_DONE: begin
                address_s = 8'h00;
                if (bus.start) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: begin
                address_s = 8'h00;
                state_s   = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= S_IDLE;
            i_r       <= 8'h00;
            j_r       <= 8'h00;
            si_r      <= 8'h00;
            sj_r      <= 8'h00;
            ksel_r    <= 2'd0;
            wcnt_r    <= 8'h00;
            address_r <= 8'h00;
            data_r    <= 8'h00;
            wren_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            i_r       <= i_s;
            j_r       <= j_s;
            si_r      <= si_s;
            sj_r      <= sj_s;
            ksel_r    <= ksel_s;
            wcnt_r    <= wcnt_s;
            address_r <= address_s;
            data_r    <= data_s;
            wren_r    <= wren_s;
            busy_r    <= (state_s != S_IDLE) && (state_s != S_DONE);
            done_r    <= (state_s == S_DONE);
        end
    end

    assign bus.address = address_r;
    assign bus.data    = data_r;
    assign bus.wren    = wren_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
endmodule
